// File: rtl/morse_keyer_if.sv
// Key input and decoded-character outputs of the Morse keyer.
// The keyer drives the outputs through the slave modport; the stimulus side uses master.
interface morse_keyer_if;
  logic       key_n;
  logic [5:0] morse_code;
  logic       code_valid;
  logic [2:0] sym_count;
  logic       busy;
  logic       err;

  modport master (
    output key_n,
    input  morse_code,
    input  code_valid,
    input  sym_count,
    input  busy,
    input  err
  );

  modport slave (
    input  key_n,
    output morse_code,
    output code_valid,
    output sym_count,
    output busy,
    output err
  );
endinterface

// File: rtl/morse_keyer.sv
// Morse keyer: key synchronizer, optional debouncer (MORSE_KEYER_DEBOUNCE_EN),
// dot/dash classification and walk of the Morse tree into a 6-bit tree index.
module morse_keyer #(
  parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000,
  parameter logic [23:0] DOT_MAX_CYCLES  = 24'd12500000,
  parameter logic [23:0] GAP_CYCLES      = 24'd25000000
) (
  input  logic          clk,
  input  logic          reset,
  morse_keyer_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRESS = 2'd1,
    GAP   = 2'd2
  } state_t;

  logic [1:0]  sync_r;
  logic        key_raw;
  logic        key_f;

  state_t      state_r;
  logic [5:0]  code_acc_r;
  logic [2:0]  sym_count_r;
  logic        ovf_r;
  logic [23:0] len_cnt_r;
  logic [23:0] gap_cnt_r;
  logic [5:0]  morse_code_r;
  logic        code_valid_r;
  logic        err_r;
  logic        busy_r;

  // Two-flop synchronizer; resets to the released level
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_r <= 2'b11;
    end else begin
      sync_r <= {sync_r[0], bus.key_n};
    end
  end

  assign key_raw = ~sync_r[1];

`ifdef MORSE_KEYER_DEBOUNCE_EN
  logic [15:0] deb_cnt_r;
  logic        key_f_r;

  // Filtered level follows the raw level only after it has differed for DEBOUNCE_CYCLES cycles
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      deb_cnt_r <= 16'd0;
      key_f_r   <= 1'b0;
    end else if (key_raw != key_f_r) begin
      if (({1'b0, deb_cnt_r} + 17'd1) >= {1'b0, DEBOUNCE_CYCLES}) begin
        key_f_r   <= key_raw;
        deb_cnt_r <= 16'd0;
      end else begin
        deb_cnt_r <= deb_cnt_r + 16'd1;
      end
    end else begin
      deb_cnt_r <= 16'd0;
    end
  end

  assign key_f = key_f_r;
`else
  // DEBOUNCE_CYCLES only matters with the debouncer built in; the term folds away
  assign key_f = key_raw | (1'b0 & (DEBOUNCE_CYCLES == 16'd0));
`endif

  // Press/gap FSM with registered character outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r      <= IDLE;
      code_acc_r   <= 6'd0;
      sym_count_r  <= 3'd0;
      ovf_r        <= 1'b0;
      len_cnt_r    <= 24'd0;
      gap_cnt_r    <= 24'd0;
      morse_code_r <= 6'd0;
      code_valid_r <= 1'b0;
      err_r        <= 1'b0;
      busy_r       <= 1'b0;
    end else begin
      code_valid_r <= 1'b0;
      err_r        <= 1'b0;
      case (state_r)
        IDLE: begin
          code_acc_r  <= 6'd0;
          sym_count_r <= 3'd0;
          ovf_r       <= 1'b0;
          if (key_f) begin
            state_r   <= PRESS;
            len_cnt_r <= 24'd1;
            busy_r    <= 1'b1;
          end else begin
            busy_r    <= 1'b0;
          end
        end
        PRESS: begin
          busy_r <= 1'b1;
          if (key_f) begin
            if (len_cnt_r != 24'hFFFFFF) begin
              len_cnt_r <= len_cnt_r + 24'd1;
            end else begin
              len_cnt_r <= len_cnt_r;
            end
          end else begin
            // A sixth symbol poisons the character instead of growing the index
            if (sym_count_r == 3'd5) begin
              ovf_r <= 1'b1;
            end else begin
              code_acc_r  <= {code_acc_r[4:0], 1'b0} +
                             ((len_cnt_r <= DOT_MAX_CYCLES) ? 6'd1 : 6'd2);
              sym_count_r <= sym_count_r + 3'd1;
            end
            gap_cnt_r <= 24'd1;
            state_r   <= GAP;
          end
        end
        GAP: begin
          if (gap_cnt_r == GAP_CYCLES) begin
            if (ovf_r) begin
              err_r <= 1'b1;
            end else begin
              morse_code_r <= code_acc_r;
              code_valid_r <= 1'b1;
            end
            code_acc_r  <= 6'd0;
            sym_count_r <= 3'd0;
            ovf_r       <= 1'b0;
            state_r     <= IDLE;
            busy_r      <= 1'b0;
          end else if (key_f) begin
            state_r   <= PRESS;
            len_cnt_r <= 24'd1;
            busy_r    <= 1'b1;
          end else begin
            busy_r <= 1'b1;
            if (gap_cnt_r != 24'hFFFFFF) begin
              gap_cnt_r <= gap_cnt_r + 24'd1;
            end else begin
              gap_cnt_r <= gap_cnt_r;
            end
          end
        end
        default: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.morse_code = morse_code_r;
  assign bus.code_valid = code_valid_r;
  assign bus.sym_count  = sym_count_r;
  assign bus.busy       = busy_r;
  assign bus.err        = err_r;

endmodule

// File: tb/tb_morse_keyer.sv
// Directed bench for morse_keyer: emitted characters are checked against a
// scoreboard queue filled by the stimulus with bench-computed tree indices.
module tb_morse_keyer;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  typedef struct packed {
    logic       is_err;
    logic [5:0] code;
  } exp_t;

  exp_t exp_q[$];

  morse_keyer_if bus();

  morse_keyer #(
    .DEBOUNCE_CYCLES (16'd4),
    .DOT_MAX_CYCLES  (24'd20),
    .GAP_CYCLES      (24'd50)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Output monitor: every code_valid/err pulse must match the head of the queue
  always @(negedge clk) begin
    if (!reset && (bus.code_valid || bus.err)) begin
      exp_t e;
      check("pulse_exclusive", {31'd0, bus.code_valid & bus.err}, 32'd0);
      if (exp_q.size() == 0) begin
        check("unexpected_pulse", {26'd0, bus.morse_code}, 32'hFFFFFFFF);
      end else begin
        e = exp_q.pop_front();
        check("pulse_kind_err", {31'd0, bus.err}, {31'd0, e.is_err});
        if (!e.is_err) begin
          check("morse_code", {26'd0, bus.morse_code}, {26'd0, e.code});
        end
      end
    end
  end

  task automatic idle_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input int n);
    @(negedge clk);
    bus.key_n = 1'b0;
    repeat (n) @(negedge clk);
    bus.key_n = 1'b1;
  endtask

  task automatic wait_drain(input string tag);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    check(tag, exp_q.size(), 32'd0);
    idle_cycles(3);
  endtask

  // mask bit i set = symbol i is a 40-cycle dash, else a 10-cycle dot
  task automatic send_char(input int n, input logic [5:0] mask, input logic expect_err, input string tag);
    logic [5:0] code;
    exp_t       e;
    code = 6'd0;
    for (int i = 0; i < n; i++) begin
      press(mask[i] ? 40 : 10);
      if (i < 5) code = {code[4:0], 1'b0} + (mask[i] ? 6'd2 : 6'd1);
      if (i < n - 1) idle_cycles(20);
    end
    e.is_err = expect_err;
    e.code   = code;
    exp_q.push_back(e);
    wait_drain(tag);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_code"},  {26'd0, bus.morse_code}, 32'd0);
    check({tag, "_valid"}, {31'd0, bus.code_valid}, 32'd0);
    check({tag, "_sym"},   {29'd0, bus.sym_count},  32'd0);
    check({tag, "_busy"},  {31'd0, bus.busy},       32'd0);
    check({tag, "_err"},   {31'd0, bus.err},        32'd0);
  endtask

  initial begin
    exp_t e;
    checks    = 0;
    errors    = 0;
    reset     = 1'b1;
    bus.key_n = 1'b1;
    idle_cycles(3);
    check_all_zero("reset");
    reset = 1'b0;
    idle_cycles(3);
    check_all_zero("post_reset");

    // E: one 10-cycle dot, watching busy and sym_count along the way
    @(negedge clk);
    bus.key_n = 1'b0;
    idle_cycles(8);
    check("busy_in_press", {31'd0, bus.busy}, 32'd1);
    idle_cycles(2);
    bus.key_n = 1'b1;
    idle_cycles(8);
    check("sym_count_after_dot", {29'd0, bus.sym_count}, 32'd1);
    e.is_err = 1'b0;
    e.code   = 6'd1;
    exp_q.push_back(e);
    wait_drain("drain_E");
    check("sym_count_idle", {29'd0, bus.sym_count}, 32'd0);
    check("busy_idle", {31'd0, bus.busy}, 32'd0);
    check("code_hold_E", {26'd0, bus.morse_code}, 32'd1);

    // A: dot then dash
    send_char(2, 6'b000010, 1'b0, "drain_A");

    // Dot/dash threshold: 20 cycles is a dot (E), 21 a dash (T)
    press(20);
    e.is_err = 1'b0;
    e.code   = 6'd1;
    exp_q.push_back(e);
    wait_drain("drain_len20");
    press(21);
    e.code   = 6'd2;
    exp_q.push_back(e);
    wait_drain("drain_len21");

    // Five dashes -> 62, five dots -> 31
    send_char(5, 6'b011111, 1'b0, "drain_0");
    send_char(5, 6'b000000, 1'b0, "drain_5");

    // Six dots overflow: err pulse, previous code retained
    send_char(6, 6'b000000, 1'b1, "drain_ovf");
    check("code_after_ovf", {26'd0, bus.morse_code}, 32'd31);
    check("sym_after_ovf", {29'd0, bus.sym_count}, 32'd0);

    // Reset during the third symbol discards the character
    press(10);
    idle_cycles(20);
    press(10);
    idle_cycles(20);
    @(negedge clk);
    bus.key_n = 1'b0;
    idle_cycles(6);
    check("sym_before_reset", {29'd0, bus.sym_count}, 32'd2);
    reset     = 1'b1;
    bus.key_n = 1'b1;
    idle_cycles(2);
    check_all_zero("mid_char_reset");
    reset = 1'b0;
    idle_cycles(80);
    check_all_zero("after_reset_quiet");
    send_char(1, 6'b000001, 1'b0, "drain_fresh_T");

`ifdef MORSE_KEYER_DEBOUNCE_EN
    // Short glitches must never reach the FSM
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      bus.key_n = 1'b0;
      idle_cycles(2);
      bus.key_n = 1'b1;
      for (int j = 0; j < 8; j++) begin
        @(negedge clk);
        check("glitch_busy", {31'd0, bus.busy}, 32'd0);
      end
    end
    idle_cycles(60);
    check("glitch_no_code", {26'd0, bus.morse_code}, 32'd2);
`endif

    check("queue_empty_end", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/morse_keyer.md
# morse_keyer

Upstream stage of the Morse display path: samples the raw Morse key, classifies each press as dot or dash by duration, and walks the binary Morse tree to produce the 6-bit tree index consumed by the combinational `morse2hex` decoder. Tree index: root 0, dot → 2·n+1, dash → 2·n+2, so E=1, T=2, A=4, S=7, O=14, 5=31, 0=62. A character is emitted when the key stays released for a letter gap; `morse_code` then holds stable for the display until the next character.

## Interface

- `DEBOUNCE_CYCLES`, 16'd50000: cycles the synchronized key must be stable before the filtered level changes.
- `DOT_MAX_CYCLES`, 24'd12500000: press length ≤ this is a dot; longer is a dash.
- `GAP_CYCLES`, 24'd25000000: released cycles ending a character.

- `clk` input 1: system clock; all state changes on rising edge.
- `reset` input 1: asynchronous, active-high; clears all state.
- `key_n` input 1: raw Morse key, active-low (pressed = 0), asynchronous to `clk`.
- `morse_code` output 6: last emitted tree index (1..62); 0 after reset.
- `code_valid` output 1: one-cycle pulse when `morse_code` updates.
- `sym_count` output 3: symbols accumulated in the character in progress (0..5).
- `busy` output 1: high whenever the FSM is not IDLE.
- `err` output 1: one-cycle pulse when a character is discarded for overflow.

## Operation

- Input path: `key_n` → 2-FF synchronizer → inverted → debouncer → `key_f` (1 = pressed).
- Working registers: `code_acc` (6 bits), `len_cnt` and `gap_cnt` (24 bits, saturating at all-ones), overflow flag `ovf`.
- FSM states:
  - IDLE: `code_acc`=0, `sym_count`=0, `ovf`=0. `key_f` rises → PRESS, `len_cnt`=1.
  - PRESS: `len_cnt` increments each cycle `key_f`=1. `key_f` falls → classify: if `sym_count`=5 set `ovf`, else `code_acc` ← 2·`code_acc` + (`len_cnt` ≤ `DOT_MAX_CYCLES` ? 1 : 2) and `sym_count`++; `gap_cnt`=1; → GAP.
  - GAP: `gap_cnt` increments while `key_f`=0. `key_f` rises before `gap_cnt` reaches `GAP_CYCLES` → PRESS, `len_cnt`=1 (same character). `gap_cnt` = `GAP_CYCLES` → if `ovf`, pulse `err` and leave `morse_code` unchanged; else `morse_code` ← `code_acc`, pulse `code_valid`. → IDLE.
- 6th and later symbols never alter `code_acc`; the entire character is dropped at its gap.
- Maximum index 2·30+2 = 62; no arithmetic exceeds 6 bits.
- Index values with no display glyph (18, 20, 29…) are still emitted; blanking is the downstream decoder's job.

## Timing

- Reset values: `morse_code`=0, `code_valid`=0, `sym_count`=0, `busy`=0, `err`=0, FSM=IDLE, synchronizer and debouncer to released.
- Key-to-`key_f` latency: 2 sync cycles + `DEBOUNCE_CYCLES`.
- `code_valid`/`err` asserted the cycle after `gap_cnt` reaches `GAP_CYCLES`, exactly one cycle wide; never both in the same cycle.
- `sym_count` updates the cycle after the falling edge of `key_f`.
- Press and gap hitting thresholds in the same cycle is impossible (mutually exclusive states); a press arriving in the emission cycle is taken by IDLE on the following cycle.
- Reset mid-press or mid-gap: partial character discarded, no pulse; `morse_code` returns to 0.
- A key held indefinitely saturates `len_cnt` and classifies as dash on release.

## Configuration

- `MORSE_KEYER_DEBOUNCE_EN` defined: debouncer present as above.
- Undefined: debouncer omitted, `key_f` = inverted synchronizer output (latency 2 cycles); `DEBOUNCE_CYCLES` ignored. Used in simulation and with externally debounced keys.

## Test plan

(Parameters for bench: `DEBOUNCE_CYCLES`=4, `DOT_MAX_CYCLES`=20, `GAP_CYCLES`=50.)
- One 10-cycle press, then release 60 cycles → single `code_valid`, `morse_code`=1 (E), `sym_count` returned to 0.
- Press 10, gap 20, press 40, release → `morse_code`=4 (A); press length exactly 20 → dot, 21 → dash.
- Five 40-cycle dashes separated by 20-cycle gaps → `morse_code`=62 (0); five dots → 31 (5).
- Six dots then gap → `err` pulse, no `code_valid`, `morse_code` keeps previous value.
- Assert `reset` during third symbol of a character → all outputs 0, no pulse; next press starts fresh character.
- With `MORSE_KEYER_DEBOUNCE_EN`: 2-cycle glitches on `key_n` → no FSM activity, `busy` stays 0.
